// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply or restoring divide over XLEN cycles on operand
// magnitudes; the sign is applied once in FIX. Divide-by-zero and signed
// overflow are resolved at accept and skip straight to DONE.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [2:0]          op;
  logic                neg;
  // Multiplicand (multiply) or divisor (divide), as a magnitude.
  logic [XLEN-1:0]     opnd;
  // Multiply: {product hi, product lo / remaining multiplier bits}.
  // Divide:   {remainder, quotient / remaining dividend bits}.
  logic [2*XLEN-1:0]   acc, acc_nxt;

  logic                accept, is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     mag_a, mag_b, special_res, fix_res;
  logic [XLEN:0]       sum, sh, diff;
  logic [2*XLEN-1:0]   prod;

  // kill_i in IDLE suppresses an accept in the same cycle.
  assign accept   = (state == IDLE) && valid_i && !kill_i;
  assign is_div   = funct3_i[2];
  assign sgn_a    = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign sgn_b    = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                    (funct3_i == 3'b110);
  assign neg_a    = sgn_a && rs1_i[XLEN-1];
  assign neg_b    = sgn_b && rs2_i[XLEN-1];
  assign mag_a    = neg_a ? -rs1_i : rs1_i;
  assign mag_b    = neg_b ? -rs2_i : rs2_i;
  assign div_zero = is_div && (rs2_i == '0);
  assign div_ovf  = is_div && !funct3_i[0] && (rs2_i == '1) &&
                    (rs1_i == {1'b1, {(XLEN-1){1'b0}}});
  assign special  = div_zero || div_ovf;
  // funct3[1] distinguishes REM* from DIV*.
  assign special_res = div_zero ? (funct3_i[1] ? rs1_i : '1)
                                : (funct3_i[1] ? '0 : rs1_i);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; kill aborts any busy state back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (kill_i) state_nxt = IDLE;
            else if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = kill_i ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; a kill in DONE swallows the done pulse
  always_comb begin
    ready_o = (state == IDLE);
    busy_o  = (state != IDLE);
    done_o  = (state == DONE) && !kill_i;
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = sh - {1'b0, opnd};
    if (op[2])
      acc_nxt = diff[XLEN] ? {sh[XLEN-1:0],   acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {sum, acc[XLEN-1:1]};
  end

  // Sign fix-up and result select
  always_comb begin
    prod = neg ? -acc : acc;
    case (op)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:                fix_res = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  // Operand latch at accept, iteration in CALC, result write on FIX->DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op       <= '0;
      neg      <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      result_o <= '0;
    end else if (accept) begin
      op   <= funct3_i;
      neg  <= (funct3_i == 3'b110) ? neg_a : (neg_a ^ neg_b);
      cnt  <= CW'(XLEN-1);
      opnd <= is_div ? mag_b : mag_a;
      acc  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      if (special) result_o <= special_res;
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
    end else if (state == FIX && !kill_i) begin
      result_o <= fix_res;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + randomized bench for muldiv_seq. The reference model works
// from RV32M arithmetic on 64-bit integers, not from the datapath.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset, valid_i, kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic        ready_o, busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .kill_i(kill_i), .ready_o(ready_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      default: p = 0;
    endcase
    if (f < 4) return f == 0 ? p[31:0] : p[63:32];
    if (b == 0) return (f == 3'd6 || f == 3'd7) ? a : 32'hFFFF_FFFF;
    if (is_special(f, a, b)) return (f == 3'd4) ? 32'h8000_0000 : 32'h0;
    case (f)
      3'd4: q = sa / sb;
      3'd5: q = ua / ub;
      3'd6: q = sa % sb;
      default: q = ua % ub;
    endcase
    return q[31:0];
  endfunction

  // Issue one op, scramble inputs after accept, and check latency/result.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n, lat;
    logic got, rdy_low;
    logic [31:0] exp;
    exp = ref_model(f, a, b);
    lat = is_special(f, a, b) ? 1 : 34;
    @(negedge clk);
    valid_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
    chk({tag, " ready_before"}, {63'b0, ready_o}, 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0; funct3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
    n = 0; got = 1'b0; rdy_low = 1'b1;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (ready_o) rdy_low = 1'b0;
      if (done_o) got = 1'b1;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, {32'b0, result_o}, {32'b0, exp});
    chk({tag, " ready_low"}, {63'b0, rdy_low}, 64'd1);
    @(negedge clk);
    chk({tag, " ready_after"}, {63'b0, ready_o}, 64'd1);
    chk({tag, " done_pulse"}, {63'b0, done_o}, 64'd0);
    last_exp = exp;
  endtask

  initial begin
    int n;
    logic seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    reset = 1'b1; valid_i = 1'b0; kill_i = 1'b0;
    funct3_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset ready", {63'b0, ready_o}, 64'd1);
    chk("reset busy", {63'b0, busy_o}, 64'd0);
    chk("reset done", {63'b0, done_o}, 64'd0);
    chk("reset result", {32'b0, result_o}, 64'd0);
    reset = 1'b0;

    // Directed cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    chk("mul value", {32'b0, last_exp}, 64'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, "mulhsu");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, "mulhu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd5, 32'd5, 32'd0, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Kill in cycle 10 of a DIV
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(posedge clk);
    #1 valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill ready", {63'b0, ready_o}, 64'd1);
    chk("kill busy", {63'b0, busy_o}, 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk("kill no_done", {63'b0, seen}, 64'd0);
    chk("kill result_held", {32'b0, result_o}, {32'b0, last_exp});
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_after_kill");
    chk("mulhu value", {32'b0, last_exp}, 64'hFFFF_FFFE);

    // Reset in cycle 5 of a MUL
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid ready", {63'b0, ready_o}, 64'd1);
    chk("rst_mid busy", {63'b0, busy_o}, 64'd0);
    chk("rst_mid done", {63'b0, done_o}, 64'd0);
    chk("rst_mid result", {32'b0, result_o}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk("rst_mid no_done", {63'b0, seen}, 64'd0);

    // valid with reset+kill, then valid with kill alone: no accept
    reset = 1'b1; kill_i = 1'b1; valid_i = 1'b1; funct3_i = 3'd0;
    @(negedge clk);
    chk("rst_kill busy", {63'b0, busy_o}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("kill_idle busy", {63'b0, busy_o}, 64'd0);
    chk("kill_idle ready", {63'b0, ready_o}, 64'd1);
    kill_i = 1'b0; valid_i = 1'b0;

    // Back-to-back: valid held high across two ops
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
    end
    chk("b2b first_latency", 64'(n), 64'd34);
    chk("b2b first_result", {32'b0, result_o}, 64'd14);
    @(negedge clk);
    chk("b2b ready_after_done", {63'b0, ready_o}, 64'd1);
    funct3_i = 3'd7;
    @(negedge clk);
    valid_i = 1'b0;
    chk("b2b second_accept", {63'b0, busy_o}, 64'd1);
    n = 1; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
    end
    chk("b2b second_latency", 64'(n), 64'd34);
    chk("b2b second_result", {32'b0, result_o}, 64'd2);

    // Randomized ops with corner-biased operands
    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, $sformatf("rnd%0d f%0d %h %h", k, rf, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
